// File: rtl/johnson_ctrl_pkg.sv
// Shared definitions for the Johnson ring controller: opcodes, FSM states and
// pattern helpers (legality and phase recovery from a loaded pattern).
package johnson_ctrl_pkg;

  localparam logic [2:0] OP_STOP  = 3'd0;
  localparam logic [2:0] OP_RUN   = 3'd1;
  localparam logic [2:0] OP_STEP  = 3'd2;
  localparam logic [2:0] OP_LOAD  = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  // Phase of a Johnson pattern: ones count while filling (MSB set or all zero),
  // 2*width minus ones count while draining.
  function automatic logic [5:0] phase_from_pattern(input logic [15:0] pat, input int width);
    logic [5:0] ones;
    ones = 6'd0;
    for (int i = 0; i < 16; i++) begin
      ones = ones + ((i < width) ? 6'(pat[i]) : 6'd0);
    end
    return (pat[width-1] || (ones == 6'd0)) ? ones : (6'(2 * width) - ones);
  endfunction

  // A legal Johnson state has at most one transition between adjacent bits.
  function automatic logic legal_pattern(input logic [15:0] pat, input int width);
    logic [4:0] edges;
    edges = 5'd0;
    for (int i = 0; i < 15; i++) begin
      edges = edges + (((i < width - 1) && (pat[i] != pat[i+1])) ? 5'd1 : 5'd0);
    end
    return (edges <= 5'd1);
  endfunction

endpackage

// File: rtl/johnson_prescaler.sv
// Advance-tick prescaler: counts 0..DIVISOR-1 while enabled, tick on the last count.
module johnson_prescaler #(
  parameter int DIVISOR = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [27:0] LAST = 28'(DIVISOR - 1);

  logic [27:0] r_cnt;

  // Prescaler count; clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 28'd0;
    end else if (clr) begin
      r_cnt <= 28'd0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? 28'd0 : (r_cnt + 28'd1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign tick = en & (r_cnt == LAST);

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run/stop/step/load controller for a WIDTH-bit Johnson ring.
// Build option: define JOHNSON_LEGAL_CHECK_EN to reject illegal LOAD patterns (sets sticky err).
module johnson_seq_ctrl
  import johnson_ctrl_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int DIVISOR = 50000000,
  localparam int PW      = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase_idx,
  output logic             tick,
  output logic             wrap,
  output logic             busy,
  output logic             err
);

  localparam logic [PW-1:0] LAST_PH = PW'(2 * WIDTH - 1);

  state_t           r_state, w_state_nx;
  logic             r_dir, w_dir_nx;
  logic             r_ready, r_busy, r_wrap, w_wrap_nx, r_err, w_err_nx;
  logic [WIDTH-1:0] r_q, w_q_nx;
  logic [PW-1:0]    r_phase, w_phase_nx, w_load_phase;
  logic [15:0]      w_pat16;
  logic             w_accept, w_acc_run, w_acc_step, w_acc_stop, w_acc_load, w_acc_clear;
  logic             w_ps_tick, w_ps_clr, w_cmd_wins, w_tick, w_adv;

  assign w_accept    = cmd_valid & r_ready;
  assign w_acc_stop  = w_accept & (cmd_op == OP_STOP);
  assign w_acc_run   = w_accept & (cmd_op == OP_RUN);
  assign w_acc_step  = w_accept & (cmd_op == OP_STEP);
  assign w_acc_load  = w_accept & (cmd_op == OP_LOAD);
  assign w_acc_clear = w_accept & (cmd_op == OP_CLEAR);

  // A command landing in a tick cycle cancels that advance.
  assign w_cmd_wins = w_acc_stop | w_acc_load | w_acc_clear;
  assign w_tick     = w_ps_tick & ~w_cmd_wins;
  assign w_adv      = w_tick | (r_state == ST_STEP);

  assign w_pat16      = 16'(cmd_data);
  assign w_load_phase = PW'(phase_from_pattern(w_pat16, WIDTH));

  johnson_prescaler #(.DIVISOR(DIVISOR)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (r_state == ST_RUN),
    .clr  (w_ps_clr),
    .tick (w_ps_tick)
  );

  // Next-state, direction latch and prescaler clear.
  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    w_ps_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ps_clr = 1'b1;
        if (w_acc_run) begin
          w_state_nx = ST_RUN;
          w_dir_nx   = cmd_dir;
        end else if (w_acc_step) begin
          w_state_nx = ST_STEP;
          w_dir_nx   = cmd_dir;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_ps_clr   = w_cmd_wins;
        w_state_nx = w_acc_stop ? ST_IDLE : ST_RUN;
      end
      ST_STEP: begin
        w_ps_clr   = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_ps_clr   = 1'b1;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Pattern, phase, wrap and error next values.
  always_comb begin
    w_q_nx     = r_q;
    w_phase_nx = r_phase;
    w_wrap_nx  = 1'b0;
    w_err_nx   = r_err;
    if (w_acc_clear) begin
      w_q_nx     = '0;
      w_phase_nx = '0;
      w_err_nx   = 1'b0;
    end else if (w_acc_load) begin
`ifdef JOHNSON_LEGAL_CHECK_EN
      if (legal_pattern(w_pat16, WIDTH)) begin
        w_q_nx     = cmd_data;
        w_phase_nx = w_load_phase;
      end else begin
        w_q_nx     = '0;
        w_phase_nx = '0;
        w_err_nx   = 1'b1;
      end
`else
      w_q_nx     = cmd_data;
      w_phase_nx = w_load_phase;
`endif
    end else if (w_adv) begin
      if (r_dir) begin
        w_q_nx     = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
        w_wrap_nx  = (r_phase == '0);
        w_phase_nx = (r_phase == '0) ? LAST_PH : (r_phase - PW'(1));
      end else begin
        w_q_nx     = {~r_q[0], r_q[WIDTH-1:1]};
        w_wrap_nx  = (r_phase == LAST_PH);
        w_phase_nx = (r_phase == LAST_PH) ? '0 : (r_phase + PW'(1));
      end
    end else begin
      w_q_nx     = r_q;
      w_phase_nx = r_phase;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_q     <= '0;
      r_phase <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_dir   <= w_dir_nx;
      r_ready <= (w_state_nx != ST_STEP);
      r_busy  <= (w_state_nx != ST_IDLE);
      r_q     <= w_q_nx;
      r_phase <= w_phase_nx;
      r_wrap  <= w_wrap_nx;
      r_err   <= w_err_nx;
    end
  end

  assign cmd_ready = r_ready;
  assign q         = r_q;
  assign phase_idx = r_phase;
  assign tick      = w_tick;
  assign wrap      = r_wrap;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: one instance at DIVISOR=4, one at DIVISOR=1.
module tb_johnson_seq_ctrl;
  import johnson_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cmd_valid, cmd_ready, cmd_dir, tick, wrap, busy, err;
  logic [2:0] cmd_op, phase_idx;
  logic [3:0] cmd_data, q;

  logic       rst_b, cmd_valid_b, cmd_ready_b, tick_b, wrap_b, busy_b, err_b;
  logic [2:0] phase_b;
  logic [3:0] q_b;

  johnson_seq_ctrl #(.WIDTH(4), .DIVISOR(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dir(cmd_dir), .cmd_data(cmd_data), .q(q), .phase_idx(phase_idx), .tick(tick),
    .wrap(wrap), .busy(busy), .err(err)
  );

  johnson_seq_ctrl #(.WIDTH(4), .DIVISOR(1)) dut_b (
    .clk(clk), .rst(rst_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(OP_RUN),
    .cmd_dir(1'b0), .cmd_data(4'd0), .q(q_b), .phase_idx(phase_b), .tick(tick_b),
    .wrap(wrap_b), .busy(busy_b), .err(err_b)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  typedef struct {
    int         edge_n;
    logic [3:0] q;
    logic [2:0] ph;
    logic       wrap;
  } sb_item_t;
  sb_item_t sb_q[$];

  logic [3:0] fwd_tab [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                              4'b0111, 4'b0011, 4'b0001, 4'b0000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic sb_push(input int e, input logic [3:0] qv, input logic [2:0] ph, input logic w);
    sb_item_t it;
    it.edge_n = e;
    it.q      = qv;
    it.ph     = ph;
    it.wrap   = w;
    sb_q.push_back(it);
  endtask

  task automatic send(input logic [2:0] op, input logic dir, input logic [3:0] data,
                      output int acc_edge);
    check_val("ready_at_send", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dir   = dir;
    cmd_data  = data;
    @(posedge clk);
    #1;
    acc_edge  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Tick monitor: every advance must match the oldest scoreboard entry.
  initial begin
    sb_item_t exp;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tick === 1'b1) begin
        check_val("tick_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp = sb_q.pop_front();
          check_val("tick_edge", 32'(cyc + 1), 32'(exp.edge_n));
          @(posedge clk);
          #1;
          check_val("adv_q", 32'(q), 32'(exp.q));
          check_val("adv_phase", 32'(phase_idx), 32'(exp.ph));
          check_val("adv_wrap", 32'(wrap), 32'(exp.wrap));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, e2, e3;
    rst = 1'b1; rst_b = 1'b1;
    cmd_valid = 1'b0; cmd_op = OP_STOP; cmd_dir = 1'b0; cmd_data = 4'd0;
    cmd_valid_b = 1'b0;

    @(negedge clk);
    check_val("rst_q", 32'(q), 32'd0);
    check_val("rst_phase", 32'(phase_idx), 32'd0);
    check_val("rst_tick", 32'(tick), 32'd0);
    check_val("rst_wrap", 32'(wrap), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; rst_b = 1'b0;
    @(posedge clk);
    #1;
    check_val("ready_after_release", 32'(cmd_ready), 32'd1);

    // Free run forward through one full period.
    send(OP_RUN, 1'b0, 4'd0, e0);
    check_val("run_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 8; k++) sb_push(e0 + 4 * k, fwd_tab[k-1], 3'(k % 8), (k == 8));
    wait_until(e0 + 32);
    check_val("sb_drain_run", 32'(sb_q.size()), 32'd0);

    // STOP presented in the tick cycle: no advance, tick suppressed.
    wait_until(e0 + 35);
    cmd_valid = 1'b1; cmd_op = OP_STOP;
    @(negedge clk);
    check_val("stop_tick_masked", 32'(tick), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_val("stop_busy", 32'(busy), 32'd0);
    check_val("stop_q_hold", 32'(q), 32'd0);
    check_val("stop_phase_hold", 32'(phase_idx), 32'd0);

    // Restart: first tick exactly DIVISOR cycles after acceptance.
    send(OP_RUN, 1'b0, 4'd0, e1);
    sb_push(e1 + 4, 4'b1000, 3'd1, 1'b0);
    wait_until(e1 + 4);
    check_val("sb_drain_rerun", 32'(sb_q.size()), 32'd0);

    // LOAD while running restarts the prescaler.
    send(OP_LOAD, 1'b0, 4'b0111, e2);
    check_val("load_q", 32'(q), 32'h7);
    check_val("load_phase", 32'(phase_idx), 32'd5);
    check_val("load_busy", 32'(busy), 32'd1);
    sb_push(e2 + 4, 4'b0011, 3'd6, 1'b0);
    wait_until(e2 + 4);
    check_val("sb_drain_load", 32'(sb_q.size()), 32'd0);

    // LOAD landing on a tick: loaded value wins, no wrap.
    wait_until(e2 + 7);
    send(OP_LOAD, 1'b0, 4'b1110, e3);
    check_val("load_tick_q", 32'(q), 32'he);
    check_val("load_tick_phase", 32'(phase_idx), 32'd3);
    check_val("load_tick_wrap", 32'(wrap), 32'd0);
    send(OP_STOP, 1'b0, 4'd0, e3);
    send(OP_CLEAR, 1'b0, 4'd0, e3);
    check_val("clear_q", 32'(q), 32'd0);
    check_val("clear_phase", 32'(phase_idx), 32'd0);

    // Illegal pattern handling.
    send(OP_LOAD, 1'b0, 4'b0110, e3);
`ifdef JOHNSON_LEGAL_CHECK_EN
    check_val("illegal_q", 32'(q), 32'd0);
    check_val("illegal_phase", 32'(phase_idx), 32'd0);
    check_val("illegal_err", 32'(err), 32'd1);
    send(OP_RUN, 1'b0, 4'd0, e3);
    sb_push(e3 + 4, 4'b1000, 3'd1, 1'b0);
    sb_push(e3 + 8, 4'b1100, 3'd2, 1'b0);
    wait_until(e3 + 8);
    check_val("err_sticky", 32'(err), 32'd1);
    check_val("sb_drain_err", 32'(sb_q.size()), 32'd0);
    send(OP_STOP, 1'b0, 4'd0, e3);
    send(OP_CLEAR, 1'b0, 4'd0, e3);
    check_val("clear_err", 32'(err), 32'd0);
`else
    check_val("raw_load_q", 32'(q), 32'h6);
    check_val("raw_load_phase", 32'(phase_idx), 32'd6);
    check_val("raw_load_err", 32'(err), 32'd0);
    send(OP_CLEAR, 1'b0, 4'd0, e3);
`endif

    // Single step reverse from zero crosses the period boundary.
    send(OP_STEP, 1'b1, 4'd0, e3);
    check_val("step_ready_low", 32'(cmd_ready), 32'd0);
    check_val("step_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check_val("step_rev_q", 32'(q), 32'h1);
    check_val("step_rev_phase", 32'(phase_idx), 32'd7);
    check_val("step_rev_wrap", 32'(wrap), 32'd1);
    check_val("step_idle_busy", 32'(busy), 32'd0);
    check_val("step_ready_back", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    check_val("wrap_one_cycle", 32'(wrap), 32'd0);
    send(OP_STEP, 1'b0, 4'd0, e3);
    @(posedge clk);
    #1;
    check_val("step_fwd_q", 32'(q), 32'd0);
    check_val("step_fwd_phase", 32'(phase_idx), 32'd0);
    check_val("step_fwd_wrap", 32'(wrap), 32'd1);

    // DIVISOR=1 instance: tick every RUN cycle, async reset mid-run.
    cmd_valid_b = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_b = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_val("div1_tick", 32'(tick_b), 32'd1);
      @(posedge clk);
      #1;
      check_val("div1_q", 32'(q_b), 32'(fwd_tab[k-1]));
    end
    #2;
    rst_b = 1'b1;
    #1;
    check_val("async_rst_q", 32'(q_b), 32'd0);
    check_val("async_rst_phase", 32'(phase_b), 32'd0);
    check_val("async_rst_tick", 32'(tick_b), 32'd0);
    check_val("async_rst_busy", 32'(busy_b), 32'd0);
    check_val("async_rst_ready", 32'(cmd_ready_b), 32'd0);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
- Run/stop/step/load controller for a WIDTH-bit Johnson ring, paced by an internal prescaler tick.
- Replaces the free-running divider-plus-counter pair so board logic can start, stop, single-step, reverse and preload the display pattern through one command handshake.
- Sits between the board command source (buttons or an upstream FSM) and the LED outputs.

Parameters:
- WIDTH, 4, Johnson ring length; sequence period is 2*WIDTH states; legal range 2 to 16.
- DIVISOR, 50000000, clk cycles per advance tick; legal minimum is 1; 28-bit prescaler.
- PW, $clog2(2*WIDTH), phase index width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller accepts a command this cycle
- cmd_op  in  3  opcode: 0 STOP, 1 RUN, 2 STEP, 3 LOAD, 4 CLEAR; 5-7 reserved (accepted, no effect)
- cmd_dir  in  1  sampled on RUN/STEP acceptance: 0 forward, 1 reverse
- cmd_data  in  WIDTH  pattern for LOAD
- q  out  WIDTH  Johnson pattern
- phase_idx  out  PW  position 0 to 2*WIDTH-1
- tick  out  1  one-cycle pulse; q advances on the closing edge of this cycle
- wrap  out  1  one-cycle pulse, registered with the advance that crosses the period boundary
- busy  out  1  state != IDLE
- err  out  1  sticky illegal-load flag

Behaviour:
- Reset (async assert, sync to clk edge on release):
  - q=0, phase_idx=0, tick=0, wrap=0, err=0, busy=0, state=IDLE, prescaler=0, dir=0.
  - cmd_ready=0 while rst is high and 1 from the first cycle after release.
- States:
  - IDLE: prescaler held at 0.
  - RUN: prescaler counts.
  - STEP: one cycle; cmd_ready=0; q advances one position, then returns to IDLE.
- Accept condition: cmd_valid & cmd_ready.
- Transitions:
  - IDLE: RUN -> RUN with prescaler cleared; STEP -> STEP.
  - RUN: STOP -> IDLE; STEP is a no-op; RUN again is a no-op and does not clear the prescaler.
  - LOAD and CLEAR leave the state unchanged and clear the prescaler. CLEAR sets q=0, phase 0, err=0.
- Prescaler: counts 0..DIVISOR-1 in RUN. tick=1 in the cycle where count==DIVISOR-1, then the count wraps to 0. With DIVISOR=1, tick is high every RUN cycle.
- First tick after RUN accepted at edge T: in cycle T+DIVISOR, with q updated at the edge that ends it.
- Forward advance: q <= {~q[0], q[WIDTH-1:1]}.
  - Sequence for WIDTH=4: 0000,1000,1100,1110,1111,0111,0011,0001.
  - phase_idx increments mod 2*WIDTH; wrap when 2*WIDTH-1 -> 0.
- Reverse advance: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}; phase_idx decrements; wrap when 0 -> 2*WIDTH-1.
- Direction is latched only at RUN/STEP acceptance.
- LOAD of a legal pattern: q=cmd_data. phase_idx=popcount if q[WIDTH-1]=1 or q=0, else 2*WIDTH-popcount.
- Legal pattern definition: MSB-first run of ones then zeros, or of zeros then ones.
- Simultaneous command accept and tick: the command wins.
  - STOP: no advance, tick not asserted.
  - LOAD/CLEAR: new value, no advance, wrap=0.
- Reset mid-operation: all outputs return to reset values immediately. A command in flight is dropped.

Optional Feature:
- Macro: JOHNSON_LEGAL_CHECK_EN.
- Defined: an illegal LOAD pattern forces q=0 and phase_idx=0 and sets err. err stays set until CLEAR or rst.
- Undefined: cmd_data is loaded verbatim; phase_idx uses the popcount formula; err is tied 0. Later advances follow the shift rules on whatever pattern is loaded.

Decomposition:
- Package johnson_ctrl_pkg:
  - opcode constants OP_STOP..OP_CLEAR
  - state encoding ST_IDLE, ST_RUN, ST_STEP
  - phase-from-pattern function and legal-pattern function
- Sub-module johnson_prescaler: inputs clk, rst, en, clr; output tick; parameter DIVISOR.

Test Plan (WIDTH=4, DIVISOR=4 unless noted):
- Release rst, RUN fwd at edge 0 -> tick in cycles 4,8,12...; q=1000,1100,1110,1111,0111,0011,0001,0000; wrap=1 only with the 8th tick (cycle 32), phase_idx 7->0.
- From reset, STEP with dir=1 -> cmd_ready=0 for one cycle; q=0001, phase_idx=7, wrap=1, busy back to 0 after one cycle.
- RUN, then STOP accepted in a tick cycle (count=3) -> no advance, tick=0, busy=0. RUN again -> next tick exactly 4 cycles after acceptance.
- LOAD 0111 while RUN -> q=0111, phase_idx=5, prescaler restarts. Next tick gives q=0011, phase 6.
- With JOHNSON_LEGAL_CHECK_EN, LOAD 0110 -> q=0000, phase 0, err=1; err holds through RUN ticks; CLEAR drops err to 0.
- DIVISOR=1: RUN -> tick high every cycle. Assert rst mid-run -> q, phase_idx, tick, busy read 0 in the same cycle, before any clk edge.
